// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, bus widths,
// reset polarity and the captured-flush context payload.
package pipe_stall_ctrl_pkg;

  localparam int unsigned REG_BUS_W = 32;
  localparam int unsigned STALL_W   = 6;
  localparam int unsigned FCNT_W    = 3;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;
  typedef logic [STALL_W-1:0]   stall_vec_t;

  localparam reg_bus_t ZERO_WORD    = '0;
  localparam logic     RESET_ENABLE = 1'b1;
  localparam logic     STOP         = 1'b1;
  localparam logic     NO_STOP      = 1'b0;

  // Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; the stage after the stalling one gets a bubble.
  localparam stall_vec_t STALL_NONE = 6'b000000;
  localparam stall_vec_t STALL_IF   = 6'b000011;
  localparam stall_vec_t STALL_ID   = 6'b000111;
  localparam stall_vec_t STALL_EX   = 6'b001111;
  localparam stall_vec_t STALL_MEM  = 6'b011111;

  typedef struct packed {
    reg_bus_t          pc;
    logic [FCNT_W-1:0] left;
  } flush_ctx_t;

  // Deepest stalling stage wins: mem > ex > id > if.
  function automatic stall_vec_t stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    stall_vec_t vec;
    vec = STALL_NONE;
    if (req_mem == STOP)     vec = STALL_MEM;
    else if (req_ex == STOP) vec = STALL_EX;
    else if (req_id == STOP) vec = STALL_ID;
    else if (req_if == STOP) vec = STALL_IF;
    return vec;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_stall_monitor.sv
// Stall statistics: saturating count of stalled cycles and a sticky timeout
// raised once a single stall run reaches STALL_LIMIT cycles.
module pipe_stall_ctrl_stall_monitor
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stalled,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam int unsigned       RUN_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] run_len_next;

  // Run length of the current stall streak, pinned at the limit.
  always_comb begin
    run_len_next = run_len;
    if (!stalled)
      run_len_next = '0;
    else if (run_len != RUN_MAX)
      run_len_next = run_len + RUN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      stall_cycles  <= '0;
      run_len       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (stalled && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + CNT_W'(1);
      run_len <= run_len_next;
      if (run_len_next == RUN_MAX)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences
// multi-cycle flushes with a redirect PC, and tracks stall statistics.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_LIMIT  = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_from_if,
  input  logic                 stallreq_from_id,
  input  logic                 stallreq_from_ex,
  input  logic                 stallreq_from_mem,
  input  logic                 flush_req,
  input  logic [REG_BUS_W-1:0] flush_pc,
  output logic                 flush_ack,
  output logic [STALL_W-1:0]   stall,
  output logic                 flush,
  output logic [REG_BUS_W-1:0] new_pc,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 stall_timeout
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);

  state_t     state;
  state_t     state_next;
  flush_ctx_t ctx;
  flush_ctx_t ctx_next;
  logic       accept;

  // Next state, flush context and the same-cycle stall/ack decisions.
  always_comb begin
    state_next = state;
    ctx_next   = ctx;
    accept     = 1'b0;
    stall      = STALL_NONE;
    case (state)
      S_RUN: begin
        if (flush_req) begin
          accept        = 1'b1;
          ctx_next.pc   = flush_pc;
          ctx_next.left = FLUSH_LOAD;
          state_next    = S_FLUSH;
        end else begin
          stall = stall_encode(stallreq_from_if, stallreq_from_id,
                               stallreq_from_ex, stallreq_from_mem);
        end
      end
      S_FLUSH: begin
        if (ctx.left <= FCNT_W'(1))
          state_next = S_RUN;
        else
          ctx_next.left = ctx.left - FCNT_W'(1);
      end
      default: state_next = S_RUN;
    endcase
    // Reset overrides everything, including an in-flight flush.
    if (rst == RESET_ENABLE) begin
      stall  = STALL_NONE;
      accept = 1'b0;
    end
  end

  assign flush_ack = accept;

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state  <= S_RUN;
      ctx    <= '0;
      flush  <= 1'b0;
      new_pc <= ZERO_WORD;
    end else begin
      state  <= state_next;
      ctx    <= ctx_next;
      flush  <= (state_next == S_FLUSH);
      new_pc <= ctx_next.pc;
    end
  end

  pipe_stall_ctrl_stall_monitor #(
    .STALL_LIMIT (STALL_LIMIT),
    .CNT_W       (CNT_W)
  ) stall_monitor (
    .clk           (clk),
    .rst           (rst),
    .stalled       (|stall),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two differently parameterised instances share
// stimulus and are checked against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic        flush_req;
  logic [31:0] flush_pc;

  logic        ack_a, flush_a, tmo_a;
  logic [5:0]  stall_a;
  logic [31:0] new_pc_a;
  logic [3:0]  cyc_a;

  logic        ack_b, flush_b, tmo_b;
  logic [5:0]  stall_b;
  logic [31:0] new_pc_b;
  logic [2:0]  cyc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance parameters: [0] = dut_a, [1] = dut_b.
  int unsigned fc   [2] = '{2, 3};
  int unsigned lim  [2] = '{4, 16};
  int unsigned cw   [2] = '{4, 3};

  // Model state.
  int unsigned  m_left [2];
  logic [31:0]  m_pc   [2];
  longint       m_cnt  [2];
  int unsigned  m_run  [2];
  bit           m_tmo  [2];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.FLUSH_CYCLES(2), .STALL_LIMIT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id),
    .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(ack_a),
    .stall(stall_a), .flush(flush_a), .new_pc(new_pc_a),
    .stall_cycles(cyc_a), .stall_timeout(tmo_a)
  );

  pipe_stall_ctrl #(.FLUSH_CYCLES(3), .STALL_LIMIT(16), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id),
    .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(ack_b),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b),
    .stall_cycles(cyc_b), .stall_timeout(tmo_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall(input int d);
    if (rst) return 6'b000000;
    if (m_left[d] > 0 || flush_req) return 6'b000000;
    if (req_mem) return 6'b011111;
    if (req_ex)  return 6'b001111;
    if (req_id)  return 6'b000111;
    if (req_if)  return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic bit exp_ack(input int d);
    return !rst && (m_left[d] == 0) && flush_req;
  endfunction

  task automatic set_in(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                        input bit i_mem, input bit fr, input logic [31:0] fp);
    rst = r; req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
    flush_req = fr; flush_pc = fp;
    #1;
  endtask

  task automatic verify();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("stall%0d", d),   64'(d == 0 ? stall_a  : stall_b),  64'(exp_stall(d)));
      chk($sformatf("ack%0d", d),     64'(d == 0 ? ack_a    : ack_b),    64'(exp_ack(d)));
      chk($sformatf("flush%0d", d),   64'(d == 0 ? flush_a  : flush_b),  64'(m_left[d] > 0));
      chk($sformatf("new_pc%0d", d),  64'(d == 0 ? new_pc_a : new_pc_b), 64'(m_pc[d]));
      chk($sformatf("cycles%0d", d),  d == 0 ? 64'(cyc_a) : 64'(cyc_b),  64'(m_cnt[d]));
      chk($sformatf("timeout%0d", d), 64'(d == 0 ? tmo_a    : tmo_b),    64'(m_tmo[d]));
    end
  endtask

  // Advance one clock and apply the controller rules to the model.
  task automatic tick();
    bit stalled [2];
    for (int d = 0; d < 2; d++) stalled[d] = (exp_stall(d) != 6'b0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] = 0; m_pc[d] = 32'h0; m_cnt[d] = 0; m_run[d] = 0; m_tmo[d] = 1'b0;
      end else begin
        if (stalled[d]) begin
          if (m_cnt[d] < (64'd1 << cw[d]) - 1) m_cnt[d]++;
          if (m_run[d] < lim[d]) m_run[d]++;
        end else begin
          m_run[d] = 0;
        end
        if (m_run[d] >= lim[d]) m_tmo[d] = 1'b1;
        if (m_left[d] > 0) m_left[d]--;
        else if (flush_req) begin
          m_left[d] = fc[d];
          m_pc[d]   = flush_pc;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                      input bit i_mem, input bit fr, input logic [31:0] fp);
    set_in(r, i_if, i_id, i_ex, i_mem, fr, fp);
    verify();
    tick();
  endtask

  task automatic do_reset();
    set_in(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF);
    chk("rst_stall", 64'(stall_a), 64'h0);
    tick();
    step(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF);
    step(1, 1, 1, 1, 1, 1, 32'hFFFF_FFFF);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("rst_flush", 64'(flush_a), 64'h0);
    chk("rst_new_pc", 64'(new_pc_a), 64'h0);
    chk("rst_cycles", 64'(cyc_a), 64'h0);
    verify(); tick();

    // Priority encoding.
    set_in(0, 0, 1, 1, 0, 0, 0); chk("prio_id_ex", 64'(stall_a), 64'h0F); verify(); tick();
    set_in(0, 0, 1, 1, 1, 0, 0); chk("prio_mem", 64'(stall_a), 64'h1F); verify(); tick();
    set_in(0, 1, 0, 0, 0, 0, 0); chk("prio_if", 64'(stall_a), 64'h03); verify(); tick();

    // Flush sequence on dut_a (2 cycles); second request during flush is not acked.
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 32'h40); chk("flush_ack_n", 64'(ack_a), 64'h1); verify(); tick();
    set_in(0, 0, 0, 0, 0, 1, 32'h80);
    chk("flush_n1", 64'(flush_a), 64'h1); chk("pc_n1", 64'(new_pc_a), 64'h40);
    chk("noack_n1", 64'(ack_a), 64'h0); verify(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); chk("flush_n2", 64'(flush_a), 64'h1); verify(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); chk("flush_n3", 64'(flush_a), 64'h0); verify(); tick();
    step(0, 0, 0, 0, 0, 0, 0);

    // Flush beats every stall request.
    set_in(0, 1, 1, 1, 1, 1, 32'h100); chk("fvs_stall_n", 64'(stall_a), 64'h0); verify(); tick();
    set_in(0, 1, 1, 1, 1, 0, 0); chk("fvs_stall_f", 64'(stall_a), 64'h0); verify(); tick();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Counters: 5 stalls, 1 free, 3 stalls -> 8 (saturates to 7 on 3-bit dut_b).
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("cnt_8", 64'(cyc_a), 64'd8); chk("cnt_sat", 64'(cyc_b), 64'd7);
    chk("tmo_sticky", 64'(tmo_a), 64'h1); chk("tmo_b_clear", 64'(tmo_b), 64'h0);
    verify(); tick();
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0);

    // Reset mid-flush on dut_b (3 cycles), then a fresh request is acked.
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'h200);
    step(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); chk("abort_flush", 64'(flush_b), 64'h0); verify(); tick();
    set_in(0, 0, 0, 0, 0, 1, 32'h300); chk("reack", 64'(ack_b), 64'h1); verify(); tick();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
